alarm_controller: RTL and testbench

Alarm stage that sits directly downstream of the clock/timekeeping counters. It holds a user-set alarm time (HH:MM, BCD) and compares it against the running time digits produced by the clock counters. On a match it drives a blinking/pulsed alarm output until the user silences it or a timeout expires. It also exports the stored alarm digits so the display path can show them while the alarm is being set.

---
 rtl/alarm_controller.sv | 213 +++++++++++++++++++++
 tb/tb_alarm_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
// Holds a BCD HH:MM alarm time, compares it with the running clock digits and
// drives a blinking alarm output on the rising edge of a match until silenced,
// disabled, overridden by set mode or timed out. Stored alarm digits are
// exported so the display path can show them while the alarm is being set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alarm_controller #(
  parameter int ALARM_DURATION = 600,
  parameter int BLINK_PERIOD   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] time_h_t,
  input  logic [3:0] time_h_u,
  input  logic [2:0] time_m_t,
  input  logic [3:0] time_m_u,
  input  logic [2:0] time_s_t,
  input  logic [3:0] time_s_u,
  input  logic       set_alarm,
  input  logic       min_inc,
  input  logic       hour_inc,
  input  logic       alarm_enable,
  input  logic       alarm_off,
  output logic [1:0] alarm_h_t,
  output logic [3:0] alarm_h_u,
  output logic [2:0] alarm_m_t,
  output logic [3:0] alarm_m_u,
  output logic       alarm_out,
  output logic       alarm_active,
  output logic       setting
);

  // Counter widths sized to hold the terminal values themselves.
  localparam int DUR_W = $clog2(ALARM_DURATION + 1);
  localparam int BLK_W = $clog2(BLINK_PERIOD + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SET     = 2'd1,
    ST_RINGING = 2'd2
  } state_t;

  state_t           state_r;
  logic [DUR_W-1:0] dur_r;
  logic [BLK_W-1:0] phase_r;
  logic             match_d_r;

  logic             match_s;
  logic             trigger_s;
  logic [DUR_W-1:0] dur_next_s;
  logic [BLK_W-1:0] phase_next_s;
  logic             dur_done_s;
  logic             phase_done_s;
  logic [6:0]       min_next_s;
  logic [5:0]       hour_next_s;

  // Next BCD minute 00..59, wrapping to 00 without carrying into hours.
  function automatic logic [6:0] next_minute(input logic [2:0] m_t,
                                             input logic [3:0] m_u);
    logic [6:0] r;
    if (m_u == 4'd9) begin
      if (m_t == 3'd5) begin
        r = {3'd0, 4'd0};
      end else begin
        r = {m_t + 3'd1, 4'd0};
      end
    end else begin
      r = {m_t, m_u + 4'd1};
    end
    return r;
  endfunction

  // Next BCD hour 00..23, wrapping to 00.
  function automatic logic [5:0] next_hour(input logic [1:0] h_t,
                                           input logic [3:0] h_u);
    logic [5:0] r;
    if ((h_t == 2'd2) && (h_u == 4'd3)) begin
      r = {2'd0, 4'd0};
    end else if (h_u == 4'd9) begin
      r = {h_t + 2'd1, 4'd0};
    end else begin
      r = {h_t, h_u + 4'd1};
    end
    return r;
  endfunction

  // Alarm time equals the running time exactly at the top of the minute.
  assign match_s = (alarm_h_t == time_h_t) && (alarm_h_u == time_h_u) &&
                   (alarm_m_t == time_m_t) && (alarm_m_u == time_m_u) &&
                   (time_s_t == 3'd0) && (time_s_u == 4'd0);

  // Only the first cycle of a match may start the alarm.
  assign trigger_s = match_s & ~match_d_r & alarm_enable & ~alarm_off & ~set_alarm;

  assign dur_next_s   = dur_r + DUR_W'(1);
  assign phase_next_s = phase_r + BLK_W'(1);
  assign dur_done_s   = (dur_next_s == DUR_W'(ALARM_DURATION));
  assign phase_done_s = (phase_next_s == BLK_W'(BLINK_PERIOD));
  assign min_next_s   = next_minute(alarm_m_t, alarm_m_u);
  assign hour_next_s  = next_hour(alarm_h_t, alarm_h_u);

  // Delayed match; resets high so a clock and alarm both at 00:00 do not ring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_d_r <= 1'b1;
    end else begin
      match_d_r <= match_s;
    end
  end

  // Alarm FSM: set-mode editing, trigger, blink/timeout and silencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      alarm_h_t    <= 2'd0;
      alarm_h_u    <= 4'd0;
      alarm_m_t    <= 3'd0;
      alarm_m_u    <= 4'd0;
      alarm_out    <= 1'b0;
      alarm_active <= 1'b0;
      setting      <= 1'b0;
      dur_r        <= {DUR_W{1'b0}};
      phase_r      <= {BLK_W{1'b0}};
    end else if (set_alarm) begin
      // Set mode overrides everything, including an alarm that is ringing.
      state_r      <= ST_SET;
      alarm_out    <= 1'b0;
      alarm_active <= 1'b0;
      setting      <= 1'b1;
      dur_r        <= {DUR_W{1'b0}};
      phase_r      <= {BLK_W{1'b0}};
      if ((state_r == ST_SET) && tick) begin
        if (min_inc) begin
          {alarm_m_t, alarm_m_u} <= min_next_s;
        end else begin
          {alarm_m_t, alarm_m_u} <= {alarm_m_t, alarm_m_u};
        end
        if (hour_inc) begin
          {alarm_h_t, alarm_h_u} <= hour_next_s;
        end else begin
          {alarm_h_t, alarm_h_u} <= {alarm_h_t, alarm_h_u};
        end
      end
    end else begin
      case (state_r)
        ST_SET: begin
          state_r      <= ST_IDLE;
          alarm_out    <= 1'b0;
          alarm_active <= 1'b0;
          setting      <= 1'b0;
          dur_r        <= {DUR_W{1'b0}};
          phase_r      <= {BLK_W{1'b0}};
        end
        ST_IDLE: begin
          setting <= 1'b0;
          dur_r   <= {DUR_W{1'b0}};
          phase_r <= {BLK_W{1'b0}};
          if (trigger_s) begin
            state_r      <= ST_RINGING;
            alarm_out    <= 1'b1;
            alarm_active <= 1'b1;
          end else begin
            state_r      <= ST_IDLE;
            alarm_out    <= 1'b0;
            alarm_active <= 1'b0;
          end
        end
        ST_RINGING: begin
          setting <= 1'b0;
          if (alarm_off || !alarm_enable) begin
            state_r      <= ST_IDLE;
            alarm_out    <= 1'b0;
            alarm_active <= 1'b0;
            dur_r        <= {DUR_W{1'b0}};
            phase_r      <= {BLK_W{1'b0}};
          end else if (tick) begin
            if (dur_done_s) begin
              // Ring time exhausted: silence on the cycle after the last tick.
              state_r      <= ST_IDLE;
              alarm_out    <= 1'b0;
              alarm_active <= 1'b0;
              dur_r        <= {DUR_W{1'b0}};
              phase_r      <= {BLK_W{1'b0}};
            end else begin
              dur_r <= dur_next_s;
              if (phase_done_s) begin
                alarm_out <= ~alarm_out;
                phase_r   <= {BLK_W{1'b0}};
              end else begin
                phase_r   <= phase_next_s;
              end
            end
          end else begin
            state_r <= ST_RINGING;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          alarm_out    <= 1'b0;
          alarm_active <= 1'b0;
          setting      <= 1'b0;
          dur_r        <= {DUR_W{1'b0}};
          phase_r      <= {BLK_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for alarm_controller (ALARM_DURATION=20, BLINK_PERIOD=2).
// Expected output words are queued when stimulus is driven and compared after
// the DUT has produced the corresponding output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alarm_controller;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] time_h_t;
  logic [3:0] time_h_u;
  logic [2:0] time_m_t;
  logic [3:0] time_m_u;
  logic [2:0] time_s_t;
  logic [3:0] time_s_u;
  logic       set_alarm;
  logic       min_inc;
  logic       hour_inc;
  logic       alarm_enable;
  logic       alarm_off;
  logic [1:0] alarm_h_t;
  logic [3:0] alarm_h_u;
  logic [2:0] alarm_m_t;
  logic [3:0] alarm_m_u;
  logic       alarm_out;
  logic       alarm_active;
  logic       setting;

  alarm_controller #(.ALARM_DURATION(20), .BLINK_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .time_h_t(time_h_t), .time_h_u(time_h_u),
    .time_m_t(time_m_t), .time_m_u(time_m_u),
    .time_s_t(time_s_t), .time_s_u(time_s_u),
    .set_alarm(set_alarm), .min_inc(min_inc), .hour_inc(hour_inc),
    .alarm_enable(alarm_enable), .alarm_off(alarm_off),
    .alarm_h_t(alarm_h_t), .alarm_h_u(alarm_h_u),
    .alarm_m_t(alarm_m_t), .alarm_m_u(alarm_m_u),
    .alarm_out(alarm_out), .alarm_active(alarm_active), .setting(setting)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  exp_h    = 0;
  int  exp_m    = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (hhmm/out/act/set)", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_word();
    return {alarm_h_t, alarm_h_u, alarm_m_t, alarm_m_u, alarm_out, alarm_active, setting};
  endfunction

  function automatic logic [15:0] exp_word(input logic eo, input logic ea, input logic es);
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
    ht = 2'(exp_h / 10);
    hu = 4'(exp_h % 10);
    mt = 3'(exp_m / 10);
    mu = 4'(exp_m % 10);
    return {ht, hu, mt, mu, eo, ea, es};
  endfunction

  task automatic push_exp(input string tag, input logic eo, input logic ea, input logic es);
    sb_t e;
    e.tag = tag;
    e.exp = exp_word(eo, ea, es);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs_word(), e.exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    time_h_t = 2'(h / 10);
    time_h_u = 4'(h % 10);
    time_m_t = 3'(m / 10);
    time_m_u = 4'(m % 10);
    time_s_t = 3'(s / 10);
    time_s_u = 4'(s % 10);
  endtask

  // One clock: drive tick, queue what the outputs must be after the edge, compare.
  task automatic step(input logic t, input string tag,
                      input logic eo, input logic ea, input logic es);
    tick = t;
    push_exp(tag, eo, ea, es);
    @(posedge clk);
    #1;
    drain();
  endtask

  // Clock steps 07:29:59 -> 07:30:00; the alarm (07:30) must start ringing.
  task automatic trigger_ring(input string tag);
    set_time(7, 29, 59);
    step(1'b0, {tag, "_pre"}, 1'b0, 1'b0, 1'b0);
    set_time(7, 30, 0);
    step(1'b0, tag, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0;
    set_alarm = 1'b0; min_inc = 1'b0; hour_inc = 1'b0;
    alarm_enable = 1'b1; alarm_off = 1'b0;
    set_time(0, 0, 0);

    // Reset held with clock at 00:00:00.
    #2;
    push_exp("reset_hold", 1'b0, 1'b0, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, $sformatf("powerup_noring_%0d", i), 1'b0, 1'b0, 1'b0);

    // Set mode, minute increments with wrap and no hour carry.
    set_time(12, 0, 0);
    set_alarm = 1'b1;
    step(1'b0, "enter_set", 1'b0, 1'b0, 1'b1);
    min_inc = 1'b1;
    for (int i = 0; i < 61; i++) begin
      exp_m = (exp_m + 1) % 60;
      step(1'b1, $sformatf("min_inc_%0d", i), 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, "min_no_tick", 1'b0, 1'b0, 1'b1);
    min_inc = 1'b0; hour_inc = 1'b1;
    for (int i = 0; i < 25; i++) begin
      exp_h = (exp_h + 1) % 24;
      step(1'b1, $sformatf("hour_inc_%0d", i), 1'b0, 1'b0, 1'b1);
    end
    // Both together, then minutes alone, to reach 07:30.
    min_inc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_h = (exp_h + 1) % 24;
      exp_m = (exp_m + 1) % 60;
      step(1'b1, $sformatf("both_inc_%0d", i), 1'b0, 1'b0, 1'b1);
    end
    hour_inc = 1'b0;
    for (int i = 0; i < 23; i++) begin
      exp_m = (exp_m + 1) % 60;
      step(1'b1, $sformatf("min_to_30_%0d", i), 1'b0, 1'b0, 1'b1);
    end
    min_inc = 1'b0;
    set_alarm = 1'b0;
    step(1'b0, "leave_set", 1'b0, 1'b0, 1'b0);

    // Ring, blink every 2 ticks, time out after 20 ticks, no retrigger.
    trigger_ring("ring1_start");
    for (int k = 1; k <= 20; k++) begin
      if (k < 20) step(1'b1, $sformatf("ring1_tick_%0d", k), ~((k >> 1) & 1), 1'b1, 1'b0);
      else        step(1'b1, "ring1_timeout", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, $sformatf("hold_noretrig_%0d", i), 1'b0, 1'b0, 1'b0);

    // Ticks absent: no blink; alarm_off pulse silences.
    trigger_ring("ring2_start");
    for (int i = 0; i < 3; i++) step(1'b0, $sformatf("ring2_notick_%0d", i), 1'b1, 1'b1, 1'b0);
    alarm_off = 1'b1;
    step(1'b0, "alarm_off_silence", 1'b0, 1'b0, 1'b0);
    alarm_off = 1'b0;
    step(1'b1, "after_off", 1'b0, 1'b0, 1'b0);

    // Match with alarm_off already high does not ring.
    set_time(7, 29, 59);
    step(1'b0, "off_pre", 1'b0, 1'b0, 1'b0);
    alarm_off = 1'b1;
    set_time(7, 30, 0);
    step(1'b0, "off_blocks_ring", 1'b0, 1'b0, 1'b0);
    alarm_off = 1'b0;
    step(1'b0, "off_released_noring", 1'b0, 1'b0, 1'b0);

    // set_alarm aborts ringing.
    trigger_ring("ring3_start");
    step(1'b1, "ring3_tick1", 1'b1, 1'b1, 1'b0);
    set_alarm = 1'b1;
    step(1'b0, "set_aborts_ring", 1'b0, 1'b0, 1'b1);
    set_alarm = 1'b0;
    step(1'b0, "set_exit", 1'b0, 1'b0, 1'b0);

    // alarm_enable low silences ringing.
    trigger_ring("ring4_start");
    step(1'b1, "ring4_tick1", 1'b1, 1'b1, 1'b0);
    alarm_enable = 1'b0;
    step(1'b0, "disable_silence", 1'b0, 1'b0, 1'b0);
    alarm_enable = 1'b1;

    // Asynchronous reset mid-ring clears outputs and alarm time immediately.
    trigger_ring("ring5_start");
    step(1'b1, "ring5_tick1", 1'b1, 1'b1, 1'b0);
    #3;
    exp_h = 0;
    exp_m = 0;
    push_exp("async_reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    drain();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, "post_reset", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
